// File: rtl/register_dump_reader.sv
// Streams a range of register-file entries, one word per valid/ready handshake.
// Define REGDUMP_PARITY_EN to add the outParity output (XOR-reduce of outData).
module register_dump_reader #(
    parameter int unsigned ZERO_REG = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  firstReg,
    input  logic [4:0]  lastReg,
    output logic [5:0]  readReg,
    input  logic [63:0] readData,
    output logic        outValid,
    input  logic        outReady,
    output logic [63:0] outData,
    output logic [4:0]  outIndex,
    output logic        outLast,
    output logic        busy,
    output logic        done,
`ifdef REGDUMP_PARITY_EN
    output logic        outParity,
`endif
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  ptr_q, ptr_d;
    logic [4:0]  last_reg_q, last_reg_d;
    logic        valid_q, valid_d;
    logic [63:0] data_q, data_d;
    logic [4:0]  index_q, index_d;
    logic        olast_q, olast_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
`ifdef REGDUMP_PARITY_EN
    logic        parity_q, parity_d;
`endif

    // Handshake on the output word: outValid && outReady.
    logic handshake;
    assign handshake = valid_q && outReady;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        last_reg_d = last_reg_q;
        valid_d    = valid_q;
        data_d     = data_q;
        index_d    = index_q;
        olast_d    = olast_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    last_reg_d = lastReg;
                    ptr_d      = firstReg;
                    state_d    = READ;
                end
            end
            READ: begin
                data_d  = (ptr_q == 5'(ZERO_REG)) ? 64'h0 : readData;
                index_d = ptr_q;
                olast_d = (ptr_q == last_reg_q);
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    if (olast_q) begin
                        state_d = DONE;
                    end else begin
                        ptr_d   = ptr_q + 5'd1;
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
`ifdef REGDUMP_PARITY_EN
        parity_d = ^data_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= 5'd0;
            last_reg_q <= 5'd0;
            valid_q    <= 1'b0;
            data_q     <= 64'h0;
            index_q    <= 5'd0;
            olast_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef REGDUMP_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            last_reg_q <= last_reg_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            index_q    <= index_d;
            olast_q    <= olast_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef REGDUMP_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // ptr only moves on entry to READ, so the read address stays put elsewhere.
    assign readReg   = {1'b0, ptr_q};
    assign outValid  = valid_q;
    assign outData   = data_q;
    assign outIndex  = index_q;
    assign outLast   = olast_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef REGDUMP_PARITY_EN
    assign outParity = parity_q;
`endif
    assign dbg_state = state_q;

endmodule

// File: tb/tb_register_dump_reader.sv
// Randomized and directed bench for register_dump_reader, checked against a
// word-list model of each dump built from the range and register contents.
module tb_register_dump_reader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  firstReg;
    logic [4:0]  lastReg;
    logic [5:0]  readReg;
    logic [63:0] readData;
    logic        outValid;
    logic        outReady;
    logic [63:0] outData;
    logic [4:0]  outIndex;
    logic        outLast;
    logic        busy;
    logic        done;
`ifdef REGDUMP_PARITY_EN
    logic        outParity;
`endif
    logic [1:0]  dbg_state;

    logic [63:0] regs [32];
    assign readData = regs[readReg[4:0]];

    register_dump_reader #(.ZERO_REG(31)) dut (
        .clk(clk), .reset(reset), .start(start),
        .firstReg(firstReg), .lastReg(lastReg),
        .readReg(readReg), .readData(readData),
        .outValid(outValid), .outReady(outReady),
        .outData(outData), .outIndex(outIndex), .outLast(outLast),
        .busy(busy), .done(done),
`ifdef REGDUMP_PARITY_EN
        .outParity(outParity),
`endif
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [63:0] exp_q[$];
    logic [4:0]  exp_idx_q[$];
    logic        exp_last_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: word count from the range rule, register 31 reads as zero.
    task automatic build_expected(input logic [4:0] f, input logic [4:0] l);
        int n;
        int idx;
        exp_q.delete();
        exp_idx_q.delete();
        exp_last_q.delete();
        if (int'(l) >= int'(f)) n = int'(l) - int'(f) + 1;
        else                    n = 32 - int'(f) + int'(l) + 1;
        for (int i = 0; i < n; i++) begin
            idx = (int'(f) + i) % 32;
            exp_q.push_back(idx == 31 ? 64'h0 : regs[idx]);
            exp_idx_q.push_back(5'(idx));
            exp_last_q.push_back(i == n - 1);
        end
    endtask

    task automatic check_word();
        chk("out_data", outData, exp_q[0]);
        chk("out_index", 64'(outIndex), 64'(exp_idx_q[0]));
        chk("out_last", 64'(outLast), 64'(exp_last_q[0]));
`ifdef REGDUMP_PARITY_EN
        chk("out_parity", 64'(outParity), 64'(^exp_q[0]));
`endif
    endtask

    task automatic wait_valid(input int budget);
        int c;
        c = 0;
        while (!outValid && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("wait_valid", 64'(outValid), 64'd1);
    endtask

    task automatic run_dump(input logic [4:0] f, input logic [4:0] l,
                            input int ready_pct, input bit stall_write);
        int  cyc;
        bit  stalled;
        logic [4:0] held_idx;
        build_expected(f, l);
        stalled = 1'b0;
        @(negedge clk);
        start = 1'b1; firstReg = f; lastReg = l; outReady = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("valid_not_yet", 64'(outValid), 64'd0);
        @(negedge clk);
        chk("first_valid_latency", 64'(outValid), 64'd1);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 4000) begin
            chk("busy_mid", 64'(busy), 64'd1);
            chk("done_mid", 64'(done), 64'd0);
            chk("read_reg_bit5", 64'(readReg[5]), 64'd0);
            if (outValid && stall_write && !stalled) begin
                stalled  = 1'b1;
                held_idx = exp_idx_q[0];
                outReady = 1'b0;
                repeat (10) begin
                    regs[held_idx] = {$urandom, $urandom};
                    @(negedge clk);
                    chk("stall_valid", 64'(outValid), 64'd1);
                    chk("stall_data", outData, exp_q[0]);
                    chk("stall_index", 64'(outIndex), 64'(held_idx));
                end
            end
            outReady = ($urandom_range(99) < ready_pct);
            // Start requests and range changes while busy must be ignored.
            start    = 1'($urandom_range(1));
            firstReg = 5'($urandom_range(31));
            lastReg  = 5'($urandom_range(31));
            if (outValid && outReady) begin
                check_word();
                void'(exp_q.pop_front());
                void'(exp_idx_q.pop_front());
                void'(exp_last_q.pop_front());
                if (exp_q.size() == 0) start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("words_left", 64'(exp_q.size()), 64'd0);
        chk("done_pulse", 64'(done), 64'd1);
        chk("valid_after_last", 64'(outValid), 64'd0);
        outReady = 1'b0;
        @(negedge clk);
        chk("done_cleared", 64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; firstReg = 5'd3; lastReg = 5'd9; outReady = 1'b1;
        for (int i = 0; i < 32; i++) regs[i] = 64'(i * 3 + 1);
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(outValid), 64'd0);
        chk("rst_data", outData, 64'h0);
        chk("rst_index", 64'(outIndex), 64'd0);
        chk("rst_last", 64'(outLast), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_read_reg", 64'(readReg), 64'd0);
        reset = 1'b0; start = 1'b0; outReady = 1'b0;
        @(negedge clk);

        // Full dump with register 31 nonzero in the file but forced to zero.
        run_dump(5'd0, 5'd31, 100, 1'b0);
        run_dump(5'd5, 5'd5, 100, 1'b0);
        run_dump(5'd30, 5'd1, 60, 1'b0);
        run_dump(5'd10, 5'd12, 100, 1'b1);

`ifdef REGDUMP_PARITY_EN
        regs[3] = 64'h7;
        regs[4] = 64'h3;
        run_dump(5'd3, 5'd4, 100, 1'b0);
`endif

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
            run_dump(5'($urandom_range(31)), 5'($urandom_range(31)),
                     $urandom_range(30, 100), 1'b0);
        end

        // Abort mid-dump; reset collides with a handshake and a start.
        for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
        @(negedge clk);
        start = 1'b1; firstReg = 5'd0; lastReg = 5'd31;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_valid(20);
            chk("abort_pre_index", 64'(outIndex), 64'(k));
            outReady = 1'b1;
            @(negedge clk);
            outReady = 1'b0;
        end
        wait_valid(20);
        reset = 1'b1; start = 1'b1; outReady = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0; outReady = 1'b0;
        chk("abort_valid", 64'(outValid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_data", outData, 64'h0);
        chk("abort_read_reg", 64'(readReg), 64'd0);
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_valid", 64'(outValid), 64'd0);
            chk("abort_no_done", 64'(done), 64'd0);
        end
        run_dump(5'd0, 5'd1, 100, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
